intf_stream_tx: RTL and testbench

Transmit end of the parameterized `intf` valid/ready stream. It accepts words on a local push port and buffers them in a DEPTH-entry FIFO. It drives them one at a time onto an `intf` instance through the `tx` modport, holding each word until the receiver on the `rx` modport asserts `rdy`. It sits in generate scopes next to each `intf` instance, as the producer that matches the existing consumer modules, and stamps every transfer with a wrapping sequence number.

---
 rtl/intf_stream_pkg.sv | 15 +
 rtl/intf.sv | 15 +
 rtl/intf_stream_fifo.sv | 57 +++++
 rtl/intf_stream_tx.sv | 108 ++++++++++
 tb/tb_intf_stream_tx.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/intf_stream_pkg.sv
// Shared types and defaults for the intf valid/ready stream producer.
// The optional INTF_STREAM_TX_PARITY_EN macro enables the parity bit on the stream.
package intf_stream_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOADED = 1'b1
    } tx_state_e;

    localparam int SEQ_W_DEFAULT = 4;

    localparam string MODPORT_TX = "tx";
    localparam string MODPORT_RX = "rx";

endpackage

// File: rtl/intf.sv
// Parameterized valid/ready stream carrying a word, sequence number and parity bit.
// Producers connect through the tx modport, consumers through rx.
interface intf #(
    parameter int WIDTH = 8,
    parameter int SEQ_W = intf_stream_pkg::SEQ_W_DEFAULT
);
    logic [WIDTH-1:0] val;
    logic             vld;
    logic [SEQ_W-1:0] seq;
    logic             par;
    logic             rdy;

    modport tx (output val, output vld, output seq, output par, input rdy);
    modport rx (input val, input vld, input seq, input par, output rdy);
endinterface

// File: rtl/intf_stream_fifo.sv
// Circular-buffer FIFO with wrap-bit pointers; head is readable combinationally
// so the output stage can load it on the same edge it pops.
module intf_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic [PTR_W:0]   diff;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Same index with differing wrap bits means the writer has lapped the reader.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                   (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign diff  = wr_ptr_reg - rd_ptr_reg;
    assign level = LVL_W'(diff);
    assign head  = mem[rd_ptr_reg[PTR_W-1:0]];

endmodule

// File: rtl/intf_stream_tx.sv
// Stream producer: push port -> FIFO -> registered output stage on an intf.tx modport.
// Define INTF_STREAM_TX_PARITY_EN to generate the even-parity bit on par.
module intf_stream_tx
    import intf_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SEQ_W = SEQ_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [15:0]                sent_cnt,
    intf.tx                            tx_intf
);
    tx_state_e        state_reg;
    logic [WIDTH-1:0] val_reg;
    logic [SEQ_W-1:0] seq_reg;
    logic [15:0]      sent_reg;

    logic             fifo_empty;
    logic             fifo_full;
    logic [WIDTH-1:0] fifo_head;
    logic             xfer;
    logic             push_acc;
    logic             load_head;
    logic             bypass;
    logic             fifo_push;
    logic             load_en;
    logic [WIDTH-1:0] load_val;

    assign xfer      = (state_reg == LOADED) && tx_intf.rdy;
    assign in_ready  = !flush && !fifo_full;
    assign push_acc  = in_valid && in_ready;
    assign load_head = !flush && !fifo_empty && ((state_reg == IDLE) || xfer);
    // Only an idle stage with nothing queued may take the pushed word directly.
    assign bypass    = !flush && (state_reg == IDLE) && fifo_empty && push_acc;
    assign fifo_push = push_acc && !bypass;
    assign load_en   = load_head || bypass;
    assign load_val  = load_head ? fifo_head : in_data;

    intf_stream_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (fifo_push),
        .push_data(in_data),
        .pop      (load_head),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .level    (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            val_reg   <= '0;
            seq_reg   <= '0;
            sent_reg  <= '0;
        end else begin
            // A transfer completing on a flush edge still happened on the wire.
            if (xfer) begin
                seq_reg <= seq_reg + 1'b1;
                if (sent_reg != 16'hFFFF) begin
                    sent_reg <= sent_reg + 16'd1;
                end
            end
            if (flush) begin
                state_reg <= IDLE;
            end else if (load_en) begin
                state_reg <= LOADED;
                val_reg   <= load_val;
            end else if (xfer) begin
                state_reg <= IDLE;
            end
        end
    end

`ifdef INTF_STREAM_TX_PARITY_EN
    logic par_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_reg <= 1'b0;
        end else if (load_en) begin
            par_reg <= ^load_val;
        end
    end

    assign tx_intf.par = par_reg;
`else
    assign tx_intf.par = 1'b0;
`endif

    assign tx_intf.val = val_reg;
    assign tx_intf.vld = (state_reg == LOADED);
    assign tx_intf.seq = seq_reg;
    assign sent_cnt    = sent_reg;

endmodule

// File: tb/tb_intf_stream_tx.sv
// Bench for intf_stream_tx: directed scenarios plus randomized traffic against a
// word-queue model of the FIFO plus output register.
module tb_intf_stream_tx;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SEQ_W = 4;
`ifdef INTF_STREAM_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [2:0]  level;
    logic [15:0] sent_cnt;

    intf #(.WIDTH(WIDTH), .SEQ_W(SEQ_W)) bus ();

    intf_stream_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .flush   (flush),
        .level   (level),
        .sent_cnt(sent_cnt),
        .tx_intf (bus)
    );

    always #5 clk = ~clk;

    // Model: q holds every word held by the block in delivery order; o_m says
    // whether the front word sits in the output register, f_m counts FIFO words.
    logic [7:0] q[$];
    int         f_m;
    bit         o_m;
    int         seq_m;
    int         sent_m;
    int         errors = 0;
    int         checks = 0;

    task automatic model_reset();
        q.delete();
        f_m    = 0;
        o_m    = 1'b0;
        seq_m  = 0;
        sent_m = 0;
    endtask

    task automatic advance();
        bit xfer;
        bit push;
        bit was_idle;
        @(posedge clk);
        xfer = o_m && bus.rdy;
        push = in_valid && !flush && (f_m < DEPTH);
        if (xfer) begin
            seq_m = (seq_m + 1) % (1 << SEQ_W);
            if (sent_m < 65535) sent_m++;
        end
        if (flush) begin
            q.delete();
            f_m = 0;
            o_m = 1'b0;
        end else begin
            was_idle = !o_m;
            if (xfer) begin
                void'(q.pop_front());
                o_m = 1'b0;
            end
            if (push) q.push_back(in_data);
            if (!o_m && f_m > 0) begin
                o_m = 1'b1;
                f_m = f_m - 1 + (push ? 1 : 0);
            end else if (!o_m && push && was_idle) begin
                o_m = 1'b1;
            end else if (push) begin
                f_m++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.rdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++; if (bus.vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%0b exp=0", bus.vld); end
        checks++; if (bus.val !== 8'h00) begin errors++; $display("FAIL reset_val got=%h exp=00", bus.val); end
        checks++; if (bus.seq !== 4'd0) begin errors++; $display("FAIL reset_seq got=%0d exp=0", bus.seq); end
        checks++; if (bus.par !== 1'b0) begin errors++; $display("FAIL reset_par got=%0b exp=0", bus.par); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (sent_cnt !== 16'd0) begin errors++; $display("FAIL reset_sent got=%0d exp=0", sent_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        bus.rdy = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hA5;
        advance();
        in_valid = 1'b0;
        checks++; if (bus.vld !== 1'b1) begin errors++; $display("FAIL single_vld got=%0b exp=1", bus.vld); end
        checks++; if (bus.val !== 8'hA5) begin errors++; $display("FAIL single_val got=%h exp=a5", bus.val); end
        checks++; if (bus.seq !== 4'd0) begin errors++; $display("FAIL single_seq got=%0d exp=0", bus.seq); end
        advance();
        checks++; if (sent_cnt !== 16'd1) begin errors++; $display("FAIL single_sent got=%0d exp=1", sent_cnt); end
        checks++; if (bus.vld !== 1'b0) begin errors++; $display("FAIL single_idle got=%0b exp=0", bus.vld); end
        $display("test_single: sent A5 sent_cnt=%0d", sent_cnt);
    endtask

    task automatic test_backpressure();
        logic [7:0] words [5];
        int base;
        bus.rdy = 1'b0;
        base = seq_m;
        for (int i = 0; i < 5; i++) begin
            words[i] = 8'($urandom);
            in_valid = 1'b1;
            in_data = words[i];
            advance();
        end
        in_valid = 1'b0;
        checks++; if (bus.val !== words[0]) begin errors++; $display("FAIL bp_hold_val got=%h exp=%h", bus.val, words[0]); end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL bp_level got=%0d exp=4", level); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
        bus.rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.vld !== 1'b1) begin errors++; $display("FAIL bp_gap[%0d] vld=%0b exp=1", i, bus.vld); end
            checks++; if (bus.val !== words[i]) begin errors++; $display("FAIL bp_val[%0d] got=%h exp=%h", i, bus.val, words[i]); end
            checks++; if (bus.seq !== 4'((base + i) % 16)) begin errors++; $display("FAIL bp_seq[%0d] got=%0d exp=%0d", i, bus.seq, (base + i) % 16); end
            $display("test_backpressure: xfer %0d val=%h seq=%0d", i, bus.val, bus.seq);
            advance();
        end
        checks++; if (bus.vld !== 1'b0) begin errors++; $display("FAIL bp_drain_vld got=%0b exp=0", bus.vld); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL bp_drain_level got=%0d exp=0", level); end
    endtask

    task automatic test_async_reset();
        bus.rdy = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h3C;
        advance();
        in_valid = 1'b0;
        checks++; if (bus.vld !== 1'b1) begin errors++; $display("FAIL arst_pre_vld got=%0b exp=1", bus.vld); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.vld !== 1'b0) begin errors++; $display("FAIL arst_vld got=%0b exp=0", bus.vld); end
        checks++; if (bus.val !== 8'h00) begin errors++; $display("FAIL arst_val got=%h exp=00", bus.val); end
        checks++; if (bus.seq !== 4'd0) begin errors++; $display("FAIL arst_seq got=%0d exp=0", bus.seq); end
        checks++; if (sent_cnt !== 16'd0) begin errors++; $display("FAIL arst_sent got=%0d exp=0", sent_cnt); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL arst_level got=%0d exp=0", level); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready got=%0b exp=1", in_ready); end
        $display("test_async_reset: vld dropped before edge");
    endtask

    task automatic test_wrap();
        int pushed = 0;
        int cyc = 0;
        bus.rdy = 1'b1;
        while ((sent_m < 20 || o_m) && cyc < 100) begin
            in_valid = (pushed < 20);
            in_data = 8'($urandom);
            if (in_valid && in_ready) pushed++;
            advance();
            cyc++;
            checks++; if (bus.vld !== o_m) begin errors++; $display("FAIL wrap_vld cyc=%0d got=%0b exp=%0b", cyc, bus.vld, o_m); end
            if (o_m) begin
                checks++; if (bus.val !== q[0]) begin errors++; $display("FAIL wrap_val cyc=%0d got=%h exp=%h", cyc, bus.val, q[0]); end
            end
            checks++; if (bus.seq !== 4'(seq_m)) begin errors++; $display("FAIL wrap_seq cyc=%0d got=%0d exp=%0d", cyc, bus.seq, seq_m); end
        end
        in_valid = 1'b0;
        checks++; if (cyc >= 100) begin errors++; $display("FAIL wrap_timeout cycles=%0d limit=100", cyc); end
        checks++; if (sent_cnt !== 16'd20) begin errors++; $display("FAIL wrap_sent got=%0d exp=20", sent_cnt); end
        checks++; if (bus.seq !== 4'd4) begin errors++; $display("FAIL wrap_seq_final got=%0d exp=4", bus.seq); end
        $display("test_wrap: sent=%0d seq=%0d cycles=%0d", sent_cnt, bus.seq, cyc);
    endtask

    task automatic test_flush();
        logic [3:0] seq_before;
        logic [15:0] sent_before;
        bus.rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = 8'($urandom);
            advance();
        end
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL flush_pre_level got=%0d exp=3", level); end
        seq_before = bus.seq;
        sent_before = sent_cnt;
        flush = 1'b1;
        in_data = 8'hEE;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%0b exp=0", in_ready); end
        advance();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (bus.vld !== 1'b0) begin errors++; $display("FAIL flush_vld got=%0b exp=0", bus.vld); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL flush_level got=%0d exp=0", level); end
        checks++; if (bus.seq !== 4'(seq_m)) begin errors++; $display("FAIL flush_seq got=%0d exp=%0d", bus.seq, seq_m); end
        bus.rdy = 1'b1;
        repeat (3) advance();
        checks++; if (bus.vld !== 1'b0 || sent_cnt !== sent_before) begin
            errors++; $display("FAIL flush_absent vld=%0b sent=%0d exp vld=0 sent=%0d", bus.vld, sent_cnt, sent_before);
        end
        $display("test_flush: seq before=%0d after=%0d", seq_before, bus.seq);
    endtask

    task automatic test_parity();
        bus.rdy = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h07;
        advance();
        in_valid = 1'b0;
        checks++; if (bus.par !== PAR_EN) begin errors++; $display("FAIL par_07 got=%0b exp=%0b", bus.par, PAR_EN); end
        bus.rdy = 1'b1;
        advance();
        in_valid = 1'b1;
        in_data = 8'h03;
        advance();
        in_valid = 1'b0;
        checks++; if (bus.val !== 8'h03 || bus.par !== 1'b0) begin
            errors++; $display("FAIL par_03 val=%h par=%0b exp val=03 par=0", bus.val, bus.par);
        end
        advance();
        $display("test_parity: par_en=%0b", PAR_EN);
    endtask

    task automatic test_random();
        bit exp_par;
        for (int cyc = 0; cyc < 300; cyc++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_data = 8'($urandom);
            bus.rdy = ($urandom_range(0, 1) == 1);
            flush = ($urandom_range(0, 31) == 0);
            advance();
            checks++; if (bus.vld !== o_m) begin errors++; $display("FAIL rnd_vld cyc=%0d got=%0b exp=%0b", cyc, bus.vld, o_m); end
            checks++; if (level !== 3'(f_m)) begin errors++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", cyc, level, f_m); end
            checks++; if (in_ready !== (!flush && f_m < DEPTH)) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%0b", cyc, in_ready); end
            checks++; if (bus.seq !== 4'(seq_m)) begin errors++; $display("FAIL rnd_seq cyc=%0d got=%0d exp=%0d", cyc, bus.seq, seq_m); end
            checks++; if (sent_cnt !== 16'(sent_m)) begin errors++; $display("FAIL rnd_sent cyc=%0d got=%0d exp=%0d", cyc, sent_cnt, sent_m); end
            if (o_m) begin
                exp_par = PAR_EN ? ^q[0] : 1'b0;
                checks++; if (bus.val !== q[0]) begin errors++; $display("FAIL rnd_val cyc=%0d got=%h exp=%h", cyc, bus.val, q[0]); end
                checks++; if (bus.par !== exp_par) begin errors++; $display("FAIL rnd_par cyc=%0d got=%0b exp=%0b", cyc, bus.par, exp_par); end
            end
        end
        flush = 1'b0;
        in_valid = 1'b0;
        $display("test_random: sent=%0d", sent_cnt);
    endtask

    initial begin
        bus.rdy = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_backpressure();
        test_async_reset();
        test_wrap();
        test_flush();
        test_parity();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
